// File: rtl/xalu_muldiv_pkg.sv
// Shared encodings and result type for the E-stage multiply/divide unit.
package xalu_muldiv_pkg;

   localparam int XOP_W  = 3;
   localparam int DATA_W = 32;

   typedef enum logic [XOP_W-1:0] {
      XOP_NONE  = 3'd0,
      XOP_MULT  = 3'd1,
      XOP_MULTU = 3'd2,
      XOP_DIV   = 3'd3,
      XOP_DIVU  = 3'd4,
      XOP_MTHI  = 3'd5,
      XOP_MTLO  = 3'd6,
      XOP_RSVD  = 3'd7
   } xop_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } xstate_e;

   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              div_zero;
   } xres_t;

   function automatic logic is_muldiv(input xop_e op);
      return (op == XOP_MULT) || (op == XOP_MULTU) || (op == XOP_DIV) || (op == XOP_DIVU);
   endfunction

   function automatic logic is_mult(input xop_e op);
      return (op == XOP_MULT) || (op == XOP_MULTU);
   endfunction

endpackage

// File: rtl/xalu_muldiv_if.sv
// Issue/result bundle between the DE pipeline register and the mul/div unit.
interface xalu_muldiv_if;
   import xalu_muldiv_pkg::*;

   logic              Start;
   logic [XOP_W-1:0]  Op;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              Int_Req;
   logic              Busy;
   logic [DATA_W-1:0] HI;
   logic [DATA_W-1:0] LO;

   modport master (output Start, Op, A, B, Int_Req, input Busy, HI, LO);
   modport slave  (input Start, Op, A, B, Int_Req, output Busy, HI, LO);

endinterface

// File: rtl/xalu_muldiv_calc.sv
// Combinational mult/multu/div/divu result for the operands presented at issue.
module xalu_calc
   import xalu_muldiv_pkg::*;
(
   input  logic [XOP_W-1:0]  i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output xres_t             o_res
);

   logic signed [2*DATA_W-1:0] w_prod_s;
   logic        [2*DATA_W-1:0] w_prod_u;
   logic                       w_zero;
   logic                       w_ovf;
   logic        [DATA_W-1:0]   w_b_s;
   logic        [DATA_W-1:0]   w_b_u;
   logic signed [DATA_W-1:0]   w_quo_s;
   logic signed [DATA_W-1:0]   w_rem_s;
   logic        [DATA_W-1:0]   w_quo_u;
   logic        [DATA_W-1:0]   w_rem_u;

   assign w_prod_s = $signed(i_a) * $signed(i_b);
   assign w_prod_u = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

   // Dividing by 1 yields exactly the wrapped answer for 0x80000000 / -1, and keeps
   // the divider away from a zero divisor (that result is discarded anyway).
   assign w_zero  = (i_b == '0);
   assign w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
   assign w_b_s   = (w_zero || w_ovf) ? 32'd1 : i_b;
   assign w_b_u   = w_zero ? 32'd1 : i_b;
   assign w_quo_s = $signed(i_a) / $signed(w_b_s);
   assign w_rem_s = $signed(i_a) % $signed(w_b_s);
   assign w_quo_u = i_a / w_b_u;
   assign w_rem_u = i_a % w_b_u;

   always_comb begin
      o_res = '0;
      case (xop_e'(i_op))
         XOP_MULT: begin
            o_res.hi = w_prod_s[2*DATA_W-1:DATA_W];
            o_res.lo = w_prod_s[DATA_W-1:0];
         end
         XOP_MULTU: begin
            o_res.hi = w_prod_u[2*DATA_W-1:DATA_W];
            o_res.lo = w_prod_u[DATA_W-1:0];
         end
         XOP_DIV: begin
            o_res.hi       = w_rem_s;
            o_res.lo       = w_quo_s;
            o_res.div_zero = w_zero;
         end
         XOP_DIVU: begin
            o_res.hi       = w_rem_u;
            o_res.lo       = w_quo_u;
            o_res.div_zero = w_zero;
         end
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/xalu_muldiv.sv
// E-stage multiply/divide unit: fixed-latency busy window, HI/LO pair, mthi/mtlo writes.
module xalu_muldiv
   import xalu_muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic          clk,
   input  logic          reset,
   xalu_muldiv_if.slave  bus
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   xstate_e           r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_busy;
   logic [DATA_W-1:0] r_hi, r_lo;
   xres_t             r_pend;
   xres_t             w_res;
   xop_e              w_op;
   logic              w_launch, w_commit, w_wr_hi, w_wr_lo;

   assign w_op = xop_e'(bus.Op);

   xalu_calc u_calc (
      .i_op  (bus.Op),
      .i_a   (bus.A),
      .i_b   (bus.B),
      .o_res (w_res)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_launch    = 1'b0;
      w_commit    = 1'b0;
      w_wr_hi     = 1'b0;
      w_wr_lo     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Int_Req squashes anything issued in the same cycle.
            if (!bus.Int_Req) begin
               if (bus.Start && is_muldiv(w_op)) begin
                  w_launch    = 1'b1;
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = is_mult(w_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               end else begin
                  w_wr_hi = (w_op == XOP_MTHI);
                  w_wr_lo = (w_op == XOP_MTLO);
               end
            end
         end
         ST_RUN: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_pend  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_launch) begin
            r_pend <= w_res;
            r_busy <= 1'b1;
         end
         if (w_commit) begin
            r_busy <= 1'b0;
            if (!r_pend.div_zero) begin
               r_hi <= r_pend.hi;
               r_lo <= r_pend.lo;
            end
         end
         if (w_wr_hi) r_hi <= bus.A;
         if (w_wr_lo) r_lo <= bus.A;
      end
   end

   assign bus.Busy = r_busy;
   assign bus.HI   = r_hi;
   assign bus.LO   = r_lo;

endmodule
